// File: rtl/mix_columns_seq_if.sv
// Block handshake bundle for the sequential MixColumns stage.
// Input side: in_valid/in_ready/in_mode/data_in. Output side: out_valid/out_ready/data_out, plus busy.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  modport master (
    output in_valid, in_mode, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, in_mode, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns (forward / optional inverse).
// Transforms COLS_PER_CYCLE columns per clock in place, then presents the result on a held valid/ready output.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          INV_EN         = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  localparam int unsigned NCOL     = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned COL_W    = 32;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NCOL - COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    work_q   [NCOL];
  logic [COL_W-1:0]    work_nxt [NCOL];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    col_idx;
  logic                mode_q;
  logic                out_valid_q;
  logic [127:0]        data_out_q;
  logic [127:0]        result_c;
  logic                rdy_c;
  logic                accept;
  logic                step;
  logic                last;

  function automatic logic [7:0] xtime(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (8'h1b & {8{s[7]}});
  endfunction

  // Inverse = forward applied after the circulant [05 00 04 00] pre-pass.
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
    logic [7:0]       a [4];
    logic [7:0]       u;
    logic [7:0]       v;
    logic [7:0]       t;
    logic [COL_W-1:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    u = 8'h00;
    v = 8'h00;
    if (inv) begin
      u = xtime(xtime(a[0] ^ a[2]));
      v = xtime(xtime(a[1] ^ a[3]));
    end
    a[0] = a[0] ^ u;
    a[2] = a[2] ^ u;
    a[1] = a[1] ^ v;
    a[3] = a[3] ^ v;
    t = a[0] ^ a[1] ^ a[2] ^ a[3];
    r = '0;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = a[i] ^ t ^ xtime(a[i] ^ a[(i+1)%4]);
    return r;
  endfunction

  // Column group update: only COLS_PER_CYCLE mixers, steered by the counter.
  always_comb begin : mix_comb
    col_idx = '0;
    for (int i = 0; i < NCOL; i++) work_nxt[i] = work_q[i];
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx           = cnt_q + CNT_W'(j);
      work_nxt[col_idx] = mix_col(work_q[col_idx], mode_q);
    end
    result_c = '0;
    for (int i = 0; i < NCOL; i++) result_c[127-32*i -: 32] = work_nxt[i];
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : out_comb
    rdy_c = 1'b0;
    step  = 1'b0;
    case (state_q)
      IDLE:    rdy_c = 1'b1;
      BUSY:    step  = 1'b1;
      DONE:    rdy_c = bus.out_ready;
      default: rdy_c = 1'b0;
    endcase
    accept        = bus.in_valid & rdy_c & ~rst;
    last          = step & (cnt_q == LAST_GRP);
    bus.in_ready  = rdy_c & ~rst;
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_valid_q;
    bus.data_out  = data_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      for (int i = 0; i < NCOL; i++) work_q[i] <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NCOL; i++) work_q[i] <= bus.data_in[127-32*i -: 32];
        cnt_q  <= '0;
        mode_q <= INV_EN && bus.in_mode;
      end else if (step) begin
        for (int i = 0; i < NCOL; i++) work_q[i] <= work_nxt[i];
        cnt_q <= cnt_q + CNT_INC;
      end
      // Result register only moves on BUSY->DONE, so it is stable while valid.
      if (last) begin
        data_out_q  <= result_c;
        out_valid_q <= 1'b1;
      end else if (state_q == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: four instances (C=1/2/4 with inverse, C=1 forward-only)
// checked against a GF(2^8) multiply reference through per-instance scoreboards.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid, in_mode, out_ready;
  logic [3:0]   in_ready, out_valid, busy;
  logic [127:0] din  [4];
  logic [127:0] dout [4];
  logic [127:0] exp_in [4];
  logic [127:0] exp_q [4][$];
  logic [3:0]   acc;
  int           n_in [4];
  int           n_out [4];
  bit           rand_rdy;
  int           checks;
  int           errors;

  typedef struct {
    logic         mode;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  function automatic int unsigned cpc_of(input int g);
    case (g)
      1:       return 2;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mix_columns_seq_if bus_i ();
    assign bus_i.in_valid  = in_valid[g];
    assign bus_i.in_mode   = in_mode[g];
    assign bus_i.data_in   = din[g];
    assign bus_i.out_ready = out_ready[g];
    assign in_ready[g]     = bus_i.in_ready;
    assign out_valid[g]    = bus_i.out_valid;
    assign busy[g]         = bus_i.busy;
    assign dout[g]         = bus_i.data_out;
    mix_columns_seq #(.COLS_PER_CYCLE(cpc_of(g)), .INV_EN(g != 3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   a [4];
    logic [7:0]   acc8;
    logic [127:0] r;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = d[127-32*c-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        acc8 = 8'h00;
        for (int j = 0; j < 4; j++) acc8 = acc8 ^ gmul(base[(j-row+4)%4], a[j]);
        r[127-32*c-8*row -: 8] = acc8;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock: scoreboard work at the falling edge, then return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      acc[k] = !rst && in_valid[k] && in_ready[k];
      if (!rst && out_valid[k] && out_ready[k]) begin
        n_out[k]++;
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out inst%0d: got %h expected no output", k, dout[k]);
        end else begin
          chk($sformatf("data_out inst%0d", k), dout[k], exp_q[k].pop_front());
        end
      end
      if (acc[k]) begin
        exp_q[k].push_back(exp_in[k]);
        n_in[k]++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy)
      for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int k, input logic [127:0] d, input logic m,
                      input logic [127:0] e, input bit measure);
    int n;
    int lat;
    din[k]      = d;
    in_mode[k]  = m;
    exp_in[k]   = e;
    in_valid[k] = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc[k] && n < 200);
    in_valid[k] = 1'b0;
    if (!acc[k]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst%0d: got no accept expected accept within 200 cycles", k);
      return;
    end
    if (measure) begin
      lat = 0;
      while (!out_valid[k] && lat < 20) begin
        cyc();
        lat++;
      end
      chk($sformatf("latency inst%0d", k), 128'(lat), 128'(4 / cpc_of(k)));
    end
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    if (exp_q[k].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout inst%0d: got %0d pending expected 0", k, exp_q[k].size());
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] e;
    logic         m;

    vecs[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[2] = '{1'b0, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6};
    vecs[3] = '{1'b1, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6};

    checks    = 0;
    errors    = 0;
    rand_rdy  = 1'b0;
    rst       = 1'b1;
    in_valid  = '0;
    in_mode   = '0;
    out_ready = '1;
    acc       = '0;
    for (int k = 0; k < 4; k++) begin
      din[k] = '0;
      exp_in[k] = '0;
      n_in[k] = 0;
      n_out[k] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset ctrl inst%0d", k), 128'({in_ready[k], out_valid[k], busy[k]}), 128'(3'b000));
      chk($sformatf("reset data inst%0d", k), dout[k], 128'h0);
    end
    rst = 1'b0;
    cyc();
    chk("ready after reset", 128'(in_ready), 128'(4'b1111));

    // Known-answer vectors on every instance; forward-only instance ignores the mode bit.
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 4; v++) begin
        e = (k == 3 && vecs[v].mode) ? model(vecs[v].din, 1'b0) : vecs[v].dout;
        send(k, vecs[v].din, vecs[v].mode, e, 1'b1);
        drain(k);
      end
    end

    // Backpressure with a second block waiting, then same-cycle handover.
    out_ready[0] = 1'b0;
    send(0, vecs[0].din, 1'b0, vecs[0].dout, 1'b1);
    din[0]      = vecs[1].din;
    in_mode[0]  = 1'b1;
    exp_in[0]   = vecs[1].dout;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("held data_out", dout[0], vecs[0].dout);
      chk("held valid/ready/accept", 128'({out_valid[0], in_ready[0], acc[0]}), 128'(3'b100));
    end
    out_ready[0] = 1'b1;
    cyc();
    in_valid[0] = 1'b0;
    chk("handover accept", 128'(acc[0]), 128'(1'b1));
    chk("handover valid/busy", 128'({out_valid[0], busy[0]}), 128'(2'b01));
    drain(0);

    // Mode toggled during BUSY must not affect the block in flight.
    send(0, vecs[3].din, 1'b1, vecs[3].dout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_mode[0] = ~in_mode[0];
      cyc();
    end
    drain(0);

    // Reset in the second BUSY cycle aborts the block.
    send(0, vecs[0].din, 1'b0, vecs[0].dout, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk("abort ctrl", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b000));
    chk("abort data_out", dout[0], 128'h0);
    n_in[0] = n_in[0] - exp_q[0].size();
    exp_q[0].delete();
    cyc();
    rst = 1'b0;
    cyc();
    chk("ready after abort", 128'(in_ready[0]), 128'(1'b1));
    send(0, vecs[2].din, 1'b0, vecs[2].dout, 1'b1);
    drain(0);

    // Random streaming with random gaps and random downstream stalls.
    rand_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 100; i++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        m = 1'($urandom_range(0, 1));
        e = model(d, m && (k != 3));
        repeat ($urandom_range(0, 2)) cyc();
        send(k, d, m, e, 1'b0);
      end
      drain(k);
    end
    rand_rdy  = 1'b0;
    out_ready = '1;
    repeat (3) cyc();
    for (int k = 0; k < 4; k++)
      chk($sformatf("block count inst%0d", k), 128'(n_out[k]), 128'(n_in[k]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Parametrised, sequential successor to the combinational MixColumns stage of the AES datapath.
- Accepts a 128-bit state on a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Performs forward or (optionally) inverse MixColumns per block, selected at accept time.
- Delivers the result on a registered valid/ready output. Sits between ShiftRows and AddRoundKey in the round engine, shared by the encrypt and decrypt paths.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4 (elaboration error otherwise).
- INV_EN, 1, 1 = inverse MixColumns logic present; 0 = forward only, mode input ignored.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input block valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_mode  input  1  0 = forward, 1 = inverse; sampled at accept only.
- data_in  input  128  AES state; column c = bits [127-32c : 96-32c], byte 0 of a column = MSB byte.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- data_out  output  128  transformed state, same byte ordering as data_in.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (async assert, sync-safe deassert to IDLE): state = IDLE, column counter = 0, working register = 0, data_out = 0, out_valid = 0, busy = 0, in_ready = 0 while rst is high.
- GF(2^8) arithmetic: xtime(s) = {s[6:0],0} ^ (8'h1b & {8{s[7]}}).
  - Forward matrix rows: [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
  - Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e], built from xtime chains only; no lookup tables.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready = 1. On accept, load data_in into the working register, latch mode (forced to 0 when INV_EN = 0), counter = 0, go to BUSY.
  - BUSY: each cycle, transform columns counter .. counter+COLS_PER_CYCLE-1 in place (column 0 first), counter += COLS_PER_CYCLE. When the last group is written, copy the result to data_out, set out_valid = 1 and go to DONE.
  - BUSY takes NCYC = 4/COLS_PER_CYCLE cycles. Latency from the accept edge to out_valid high is NCYC cycles (4, 2, 1).
  - DONE: out_valid = 1 and data_out held stable until out_ready.
    - in_ready = out_ready in DONE. On output handshake with no new input, go to IDLE and clear out_valid.
    - On simultaneous output handshake and input accept, load the new block and go directly to BUSY; out_valid drops the next cycle. No bubble.
- in_ready is 0 throughout BUSY. in_valid in BUSY is ignored and not lost; the upstream holds it.
- data_out changes only on the BUSY→DONE transition; it is never updated while out_valid = 1.
- Counter wraps to 0 on BUSY exit; counter width = 2 bits.
- rst asserted mid-BUSY or in DONE aborts the block. No output is produced and all outputs return to reset values.
- Throughput: one block per NCYC+1 cycles with out_ready held high.

Test Plan:
- Forward vector, all COLS_PER_CYCLE values: in_mode = 0, data_in = db135345_f20a225c_01010101_c6c6c6c6 → data_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises exactly 4/2/1 cycles after accept.
- Inverse round-trip (INV_EN = 1): in_mode = 1, data_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → db135345_f20a225c_01010101_c6c6c6c6. Then forward of d4d4d4d5_2d26314c_… → d5d5d7d6_4d7ebdf8_… and inverse returns the original.
- Backpressure: out_ready = 0 for 10 cycles after out_valid → data_out stable, in_ready = 0, a second in_valid is not accepted. Raising out_ready with in_valid high gives a same-cycle handover and the second result is correct.
- Mode sampling: toggle in_mode during BUSY → result uses the mode latched at accept. With INV_EN = 0 and in_mode = 1, the output equals the forward result.
- Reset mid-operation: assert rst at the second BUSY cycle (COLS_PER_CYCLE = 1) → out_valid, busy, data_out = 0 immediately. After release, in_ready = 1 and the next block is correct.
- Streaming: 100 random blocks, random out_ready/in_valid, each mode → every output matches the reference model in order, with no drops or duplicates.
